// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin picker.
// Size codes follow the memory's own size-select encoding and are passed through untouched.
// No logic here: constants, the FSM encoding, the latched-transaction struct and size helpers.
package dmem_arbiter_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Everything about a granted request except its address, whose width is a module parameter.
    typedef struct packed {
        logic        we;
        logic        port;
        logic        err;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xact_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic size_legal(input logic [2:0] size, input logic we);
        case (size)
            SZ_B, SZ_H, SZ_W: return 1'b1;
            SZ_BU, SZ_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; prio names the port that wins a tie.
// Latency: grant is combinational from req; prio moves past the winner on the advance edge.
// Backpressure: none of its own; advance marks the cycle in which the grant is consumed.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = req;
        if (&req) begin
            grant = (prio == PORT1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= PORT0;
        end else if (advance) begin
            prio <= grant[0] ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the LSU (p0) and loader/debug port (p1); optional request checks under DMEM_ARB_CHECK_EN.
// Latency: gnt in the request cycle, one memory access cycle, rvalid/rdata two cycles after gnt; one transaction per two cycles.
// Backpressure: requesters hold req until gnt; the losing port is ignored until the arbiter is idle again.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [2:0]        p0_size,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [2:0]        p1_size,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_size,
    output logic              mem_rw,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              advance;

    logic              win_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [2:0]        win_size;
    logic              win_err;

    logic [ADDR_W-1:0] lat_addr;
    xact_t             lat;

    assign req_vec = {p1_req, p0_req};
    assign advance = (state == ST_IDLE) && (|req_vec);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (advance),
        .grant   (grant)
    );

    assign win_port  = grant[1] ? PORT1 : PORT0;
    assign win_we    = (win_port == PORT1) ? p1_we    : p0_we;
    assign win_addr  = (win_port == PORT1) ? p1_addr  : p0_addr;
    assign win_wdata = (win_port == PORT1) ? p1_wdata : p0_wdata;
    assign win_size  = (win_port == PORT1) ? p1_size  : p0_size;

`ifdef DMEM_ARB_CHECK_EN
    logic [ADDR_W:0] win_end;
    logic [1:0]      err_q;

    // One extra bit on the end address so a request near the top of the address space cannot wrap past the limit.
    always_comb begin
        win_end = {1'b0, win_addr} + (ADDR_W+1)'(size_bytes(win_size));
        win_err = !size_legal(win_size, win_we)
               || ((win_size[1:0] == 2'b01) && win_addr[0])
               || ((win_size == SZ_W) && (win_addr[1:0] != 2'b00))
               || (win_end > (ADDR_W+1)'(MEM_BYTES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 2'b00;
        end else begin
            err_q[0] <= (state == ST_ACCESS) && lat.err && (lat.port == PORT0);
            err_q[1] <= (state == ST_ACCESS) && lat.err && (lat.port == PORT1);
        end
    end

    assign p0_err = err_q[0];
    assign p1_err = err_q[1];
`else
    logic unused_cfg;

    assign win_err    = 1'b0;
    assign p0_err     = 1'b0;
    assign p1_err     = 1'b0;
    assign unused_cfg = ^MEM_BYTES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|req_vec) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Grants and the write strobe are gated by rst so nothing is accepted or committed on a reset edge.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        mem_rw = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    p0_gnt = grant[0];
                    p1_gnt = grant[1];
                end
                ST_ACCESS: mem_rw = lat.we && !lat.err;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            lat      <= '0;
        end else if (advance) begin
            lat_addr  <= win_addr;
            lat.we    <= win_we;
            lat.port  <= win_port;
            lat.err   <= win_err;
            lat.size  <= win_size;
            lat.wdata <= win_wdata;
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat.wdata;
    assign mem_size  = lat.size;

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= (state == ST_ACCESS) && (lat.port == PORT0);
            p1_rvalid <= (state == ST_ACCESS) && (lat.port == PORT1);
            if ((state == ST_ACCESS) && !lat.we && !lat.err) begin
                if (lat.port == PORT1) begin
                    p1_rdata <= mem_rdata;
                end else begin
                    p0_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory behind the port, transaction-level reference model in front.
// Directed cases first (reset, contention, sign/zero extension, reset mid-access, fairness), then random traffic.
// Inputs are driven and outputs sampled 1-2 ns after the rising edge.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [2:0]  p0_size;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [2:0]  p1_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_size;
    logic        mem_rw;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rw(mem_rw),
        .mem_rdata(mem_rdata)
    );

    // ---------------- memory behind the arbiter ----------------
    logic [7:0] dmem [1024];
    logic [9:0] ma;
    logic       loaded = 1'b0;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 16) return 8'h80;
        return 8'((i * 29 + 7) ^ (i >> 3));
    endfunction

    assign ma = mem_addr[9:0];

    always_comb begin
        case (mem_size)
            SZ_B:    mem_rdata = {{24{dmem[ma][7]}}, dmem[ma]};
            SZ_BU:   mem_rdata = {24'h0, dmem[ma]};
            SZ_H:    mem_rdata = {{16{dmem[ma+10'd1][7]}}, dmem[ma+10'd1], dmem[ma]};
            SZ_HU:   mem_rdata = {16'h0, dmem[ma+10'd1], dmem[ma]};
            SZ_W:    mem_rdata = {dmem[ma+10'd3], dmem[ma+10'd2], dmem[ma+10'd1], dmem[ma]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= init_byte(i);
            loaded <= 1'b1;
        end else if (mem_rw) begin
            dmem[ma] <= mem_wdata[7:0];
            if (mem_size != SZ_B) dmem[ma+10'd1] <= mem_wdata[15:8];
            if (mem_size == SZ_W) begin
                dmem[ma+10'd2] <= mem_wdata[23:16];
                dmem[ma+10'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [1024];
    int          m_prio;
    logic [31:0] m_rdata [2];

    logic        pr_req   [2];
    logic        pr_we    [2];
    logic [31:0] pr_addr  [2];
    logic [31:0] pr_wdata [2];
    logic [2:0]  pr_size  [2];

    int errors = 0;
    int checks = 0;

    function automatic int nbytes(input logic [2:0] s);
        return (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int idx(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) % 32'd1024);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
        int n;
        logic [31:0] v;
        n = nbytes(s);
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[idx(a, k)]) << (8 * k));
        if (!s[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        for (int k = 0; k < nbytes(s); k++) ref_mem[idx(a, k)] = d[8*k +: 8];
    endfunction

    function automatic logic ref_err(input logic we, input logic [31:0] a, input logic [2:0] s);
`ifdef DMEM_ARB_CHECK_EN
        if (s == 3'b011 || s == 3'b110 || s == 3'b111) return 1'b1;
        if (we && s[2]) return 1'b1;
        if (nbytes(s) == 2 && a[0]) return 1'b1;
        if (nbytes(s) == 4 && a[1:0] != 2'b00) return 1'b1;
        if (longint'(a) + longint'(nbytes(s)) > 64'd1024) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        p0_req = pr_req[0]; p0_we = pr_we[0]; p0_addr = pr_addr[0]; p0_wdata = pr_wdata[0]; p0_size = pr_size[0];
        p1_req = pr_req[1]; p1_we = pr_we[1]; p1_addr = pr_addr[1]; p1_wdata = pr_wdata[1]; p1_size = pr_size[1];
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] s);
        pr_req[p] = 1'b1; pr_we[p] = we; pr_addr[p] = a; pr_wdata[p] = d; pr_size[p] = s;
    endtask

    task automatic new_req(input int p);
        logic [2:0]  s;
        logic [31:0] a;
        logic        we;
        we = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, we ? 2 : 4))
            0:       s = SZ_B;
            1:       s = SZ_H;
            2:       s = SZ_W;
            3:       s = SZ_BU;
            default: s = SZ_HU;
        endcase
        a = $urandom_range(0, 1023);
        if (s[1:0] == 2'b01) a[0] = 1'b0;
        if (s == SZ_W) a[1:0] = 2'b00;
        set_req(p, we, a, $urandom, s);
    endtask

    // One full transaction starting in an idle cycle; returns the port the model says must win.
    task automatic slot(input logic hold, output int win);
        int   w;
        logic e;
        drive();
        #1;
        if (pr_req[0] && pr_req[1]) w = m_prio;
        else                        w = pr_req[1] ? 1 : 0;
        chk("gnt0", p0_gnt, w == 0);
        chk("gnt1", p1_gnt, w == 1);
        e = ref_err(pr_we[w], pr_addr[w], pr_size[w]);
        m_prio = 1 - w;
        @(posedge clk); #1;
        if (!hold) pr_req[w] = 1'b0;
        drive();
        #1;
        chk("access_gnt", {p1_gnt, p0_gnt}, 0);
        chk("access_rw", mem_rw, pr_we[w] && !e);
        chk("access_addr", mem_addr, pr_addr[w]);
        chk("access_size", mem_size, pr_size[w]);
        if (pr_we[w]) chk("access_wdata", mem_wdata, pr_wdata[w]);
        chk("access_rvalid", {p1_rvalid, p0_rvalid}, 0);
        if (!e) begin
            if (pr_we[w]) ref_store(pr_addr[w], pr_wdata[w], pr_size[w]);
            else          m_rdata[w] = ref_load(pr_addr[w], pr_size[w]);
        end
        @(posedge clk); #1;
        chk("rvalid", {p1_rvalid, p0_rvalid}, 32'd1 << w);
        chk("err", {p1_err, p0_err}, e ? (32'd1 << w) : 32'd0);
        chk("rdata0", p0_rdata, m_rdata[0]);
        chk("rdata1", p1_rdata, m_rdata[1]);
        win = w;
    endtask

    initial begin
        int          w;
        int          bad;
        logic [31:0] pre20;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        for (int p = 0; p < 2; p++) begin
            pr_req[p] = 1'b0; pr_we[p] = 1'b0; pr_addr[p] = '0; pr_wdata[p] = '0; pr_size[p] = '0;
            m_rdata[p] = '0;
        end
        m_prio = 0;

        // Reset: a live request must not be granted while rst is high.
        rst = 1'b1;
        pr_req[0] = 1'b1;
        pr_addr[0] = 32'h10;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt0", p0_gnt, 0);
        chk("rst_gnt1", p1_gnt, 0);
        chk("rst_rvalid", {p1_rvalid, p0_rvalid}, 0);
        chk("rst_err", {p1_err, p0_err}, 0);
        chk("rst_rdata0", p0_rdata, 0);
        chk("rst_rdata1", p1_rdata, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_size", mem_size, 0);
        rst = 1'b0;
        pr_req[0] = 1'b0;
        drive();

        // Contention from reset: port 0 first, port 1 back-to-back, then port 1 reads its word back.
        set_req(0, 1'b1, 32'h80, 32'hCAFE_F00D, SZ_W);
        set_req(1, 1'b1, 32'h84, 32'h1234_5678, SZ_W);
        slot(1'b0, w); chk("contend_first", w, 0);
        slot(1'b0, w); chk("contend_second", w, 1);
        set_req(1, 1'b0, 32'h84, 32'h0, SZ_W);
        slot(1'b0, w); chk("p1_readback", p1_rdata, 32'h1234_5678);

        // Signed byte load of 0x80.
        set_req(0, 1'b0, 32'h10, 32'h0, SZ_B);
        slot(1'b0, w); chk("load_b_sext", p0_rdata, 32'hFFFF_FF80);
        @(posedge clk); #1;
        chk("rvalid_one_cycle", {p1_rvalid, p0_rvalid}, 0);
        chk("rdata_holds", p0_rdata, 32'hFFFF_FF80);

        // Half store then back-to-back loads, unsigned and signed.
        set_req(0, 1'b1, 32'h40, 32'h1234_ABCD, SZ_H);
        slot(1'b0, w);
        set_req(0, 1'b0, 32'h40, 32'h0, SZ_HU);
        slot(1'b0, w); chk("half_zext", p0_rdata, 32'h0000_ABCD);
        set_req(0, 1'b0, 32'h40, 32'h0, SZ_H);
        slot(1'b0, w); chk("half_sext", p0_rdata, 32'hFFFF_ABCD);

        // Reset asserted during the access cycle of a store.
        pre20 = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
        set_req(0, 1'b1, 32'h20, 32'hDEAD_BEEF, SZ_W);
        drive();
        #1;
        chk("rstacc_gnt", p0_gnt, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        pr_req[0] = 1'b0;
        drive();
        #1;
        chk("rstacc_rw", mem_rw, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_prio = 0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        chk("rstacc_rvalid", {p1_rvalid, p0_rvalid}, 0);
        chk("rstacc_mem20", {dmem[35], dmem[34], dmem[33], dmem[32]}, pre20);
        chk("rstacc_rdata0", p0_rdata, 0);
        chk("rstacc_mem_addr", mem_addr, 0);

        // Fairness: both ports keep requesting; prio restarts at port 0 after the reset.
        new_req(0);
        new_req(1);
        for (int i = 0; i < 8; i++) begin
            slot(1'b1, w);
            chk("fair_order", w, i % 2);
        end
        pr_req[0] = 1'b0;
        pr_req[1] = 1'b0;
        drive();

        // Random traffic with occasional idle cycles and dropped requests.
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) if (!pr_req[p] && $urandom_range(0, 1) == 1) new_req(p);
            if (!pr_req[0] && !pr_req[1]) new_req(int'($urandom_range(0, 1)));
            slot($urandom_range(0, 3) == 0, w);
            if ($urandom_range(0, 4) == 0) begin
                pr_req[0] = 1'b0;
                pr_req[1] = 1'b0;
                drive();
                #1;
                chk("idle_gnt", {p1_gnt, p0_gnt}, 0);
                @(posedge clk); #1;
                chk("idle_rvalid", {p1_rvalid, p0_rvalid}, 0);
            end
        end
        pr_req[0] = 1'b0;
        pr_req[1] = 1'b0;

`ifdef DMEM_ARB_CHECK_EN
        set_req(0, 1'b1, 32'h22, 32'h55AA_55AA, SZ_W);
        slot(1'b0, w); chk("err_word_022", p0_err, 1);
        set_req(1, 1'b1, 32'h3FE, 32'h0BAD_0BAD, SZ_W);
        slot(1'b0, w); chk("err_word_3fe", p1_err, 1);
        set_req(0, 1'b0, 32'h3FF, 32'h0, SZ_HU);
        slot(1'b0, w); chk("err_half_odd", p0_err, 1);
        set_req(1, 1'b1, 32'h44, 32'h0000_00EE, SZ_BU);
        slot(1'b0, w); chk("err_store_bu", p1_err, 1);
        set_req(0, 1'b0, 32'h10, 32'h0, 3'b011);
        slot(1'b0, w); chk("err_size_011", p0_err, 1);
        set_req(1, 1'b1, 32'h3FC, 32'h0102_0304, SZ_W);
        slot(1'b0, w); chk("ok_word_3fc", p1_err, 0);
        pr_req[0] = 1'b0;
        pr_req[1] = 1'b0;
`endif

        drive();
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
        chk("mem_final_bytes_differing", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed data memory. Shares the single memory port between the core load/store unit (port 0) and the program loader/debug port (port 1) using round-robin arbitration. Latches each granted request, drives the memory for exactly one access cycle, and returns registered read data. Sits between the LSU/loader and the data memory, driving its address, write-data, size-select and read/write inputs.

## Interface
- ADDR_W, 32: address width of requesters and memory.
- MEM_BYTES, 1024: memory size in bytes; used only by the check feature.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pN_req  in  1  port N request (N = 0, 1); held with fields stable until pN_gnt
- pN_we  in  1  1 = store, 0 = load
- pN_addr  in  ADDR_W  byte address
- pN_wdata  in  32  store data, right-aligned
- pN_size  in  3  size select: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores use 000/001/010 only
- pN_gnt  out  1  one-cycle pulse: request accepted
- pN_rvalid  out  1  one-cycle pulse: transaction complete (loads and stores)
- pN_rdata  out  32  load data, valid with pN_rvalid; holds until next completion
- pN_err  out  1  with pN_rvalid; only with DMEM_ARB_CHECK_EN, else tied 0
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  32  to memory write data
- mem_size  out  3  to memory size select
- mem_rw  out  1  to memory write enable
- mem_rdata  in  32  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: if any req, pick winner; assert its gnt combinationally this cycle; latch we/addr/wdata/size and port ID; go to ACCESS. Else stay.
- Arbitration: both requesting → port named by priority pointer `prio` wins. One requesting → that port wins. After every grant, `prio` := other port than winner.
- ACCESS: mem_addr/mem_wdata/mem_size driven from latched registers. mem_rw = latched we. On the closing edge: memory write commits; for loads, mem_rdata captured into winner's rdata register; winner's rvalid set for the following cycle; go to IDLE.
- Outside ACCESS: mem_rw = 0; mem_addr/mem_wdata/mem_size hold last latched values.
- Non-winning port's req is ignored until the next IDLE; its gnt stays low.
- Stores: rdata unchanged, rvalid still pulses.
- Sizes are passed to the memory unmodified; sign/zero extension is done by the memory.

## Timing
- Request at cycle N (state IDLE) → gnt at N → ACCESS at N+1 → write commits at end of N+1 → rvalid/rdata at N+2.
- Throughput: one transaction per 2 cycles. Back-to-back: gnt in cycle N+2 overlaps the previous rvalid.
- Reset values: state IDLE, prio = 0, all gnt/rvalid/err = 0, all rdata = 0, mem_rw = 0, mem_addr/mem_wdata/mem_size = 0.
- Reset during ACCESS: mem_rw is gated by !rst, so no write commits on an edge with rst high. Transaction is dropped with no rvalid. Requester must re-issue.
- req dropped before gnt: no transaction. req held after gnt: treated as a new request at the next IDLE.

## Configuration
- DMEM_ARB_CHECK_EN defined: in IDLE the winner's request is checked. Error if half with addr[0] = 1, word with addr[1:0] ≠ 0, size code 011/110/111, store size not in {000, 001, 010}, or addr + bytes > MEM_BYTES.
- Erroring request: granted normally. ACCESS runs with mem_rw forced 0. rvalid and err pulse together at N+2; rdata unchanged.
- Macro undefined: no checks; pN_err tied 0; all requests are passed through.

## Structure
- Shared package holds: size-code constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), FSM state enum, port-ID constants.
- One sub-module, `rr_arb2`: 2-input round-robin picker holding `prio`; inputs req[1:0] and advance; outputs one-hot grant.

## Test plan
- Single load, port 0: memory holds 0x80 at addr 0x10; p0 load, size 000 → gnt at N, rvalid at N+2, p0_rdata = 0xFFFFFF80.
- Contention: both ports request word stores from reset → p0 granted first, p1 granted at N+2. Port 1's word read-back returns its own wdata.
- Fairness: both ports hold req continuously for 8 grants → strict alternation 0, 1, 0, 1…
- Reset in ACCESS: word store of 0xDEADBEEF to 0x20, rst high in the ACCESS cycle → memory at 0x20 unchanged, no rvalid, state IDLE, prio = 0.
- With DMEM_ARB_CHECK_EN: word store to 0x22 → rvalid and err at N+2, mem_rw never high, memory unchanged. Word store to 0x3FE → err.
- Store then load, same port, back-to-back: half store 0xABCD to 0x40, then load size 101 → rdata = 0x0000ABCD.
